control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter INSTR_W, default 16, instruction width.
REQ-002 Parameter OPC_W, default 3, opcode width in instr[INSTR_W-1 -: OPC_W]; ADDR_W = INSTR_W-OPC_W is derived.
REQ-003 Parameter PC_W, default 8, program counter width; elaboration SHALL fail unless PC_W <= ADDR_W-1.
REQ-004 Port list: clk  in  1  sole clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  level; launches program from IDLE or HALT.
REQ-007 pc  out  PC_W  instruction fetch address.
REQ-008 instr  in  INSTR_W  fetched instruction.
REQ-009 instr_valid  in  1  instr valid for current pc.
REQ-010 op_done  in  1  datapath completion of issued strobe op.
REQ-011 base_address  out  ADDR_W  registered operand address.
REQ-012 load_weight, load_input, valid, store  out  1 each  registered one-cycle strobes.
REQ-013 busy  out  1  high in FETCH/EXEC/WAIT; halted  out  1  high in HALT.

Function
REQ-014 FSM states SHALL be IDLE, FETCH, EXEC, WAIT, HALT.
REQ-015 IDLE: pc held 0; start=1 -> FETCH next cycle.
REQ-016 FETCH: pc driven; instr_valid=1 latches instr into internal IR -> EXEC; otherwise stay.
REQ-017 EXEC decodes IR opcode: 000 NOP, 001 LOAD_ADDR, 010 LOAD_WEIGHT, 011 LOAD_INPUTS, 100 VALID, 101 STORE, 110 LOOP, 111 HALT.
REQ-018 NOP: pc <= pc+1, -> FETCH.
REQ-019 LOAD_ADDR: base_address <= IR[ADDR_W-1:0], pc <= pc+1, -> FETCH.
REQ-020 LOAD_WEIGHT/LOAD_INPUTS/VALID/STORE: matching strobe high exactly the one cycle after EXEC, -> WAIT.
REQ-021 WAIT: op_done sampled from first WAIT cycle (same cycle as strobe); op_done=1 -> pc <= pc+1, -> FETCH; else stay, strobe low.
REQ-022 At most one strobe SHALL be high in any cycle; strobes never high outside the cycle after EXEC.
REQ-023 HALT opcode: -> HALT, pc frozen; start=1 in HALT -> pc <= 0, loop state cleared, -> FETCH.
REQ-024 pc increment SHALL wrap 2^PC_W-1 -> 0 without flag.
REQ-025 start ignored in FETCH/EXEC/WAIT; op_done ignored outside WAIT; instr_valid ignored outside FETCH.
REQ-026 base_address SHALL hold its value across all opcodes except LOAD_ADDR.

Reset
REQ-027 reset=0 SHALL immediately force IDLE, pc=0, base_address=0, IR=0, loop counter=0, loop_active=0, all strobes/busy/halted=0, including mid-WAIT.
REQ-028 After reset release, a start is required; no strobe before first EXEC.

Configuration
REQ-029 Macro CTRL_SEQ_LOOP_EN SHALL enable opcode 110 LOOP: count=IR[ADDR_W-1:PC_W], target=IR[PC_W-1:0].
REQ-030 LOOP with loop_active=0: count=0 -> pc+1; else loop_cnt <= count-1, loop_active=1, pc <= target; -> FETCH.
REQ-031 LOOP with loop_active=1: loop_cnt=0 -> loop_active=0, pc+1; else loop_cnt-1, pc <= target; single level, nested LOOP shares the counter.
REQ-032 Without CTRL_SEQ_LOOP_EN, opcode 110 SHALL behave as NOP and no loop registers exist.

Verification
REQ-033 Reset, start, program {001 addr 0x0A5, 111} -> base_address=0x0A5 after 2nd FETCH, halted=1, no strobes.
REQ-034 Program {010}, op_done held low 5 cycles then high -> load_weight high exactly 1 cycle, busy high throughout, pc 0->1 after op_done.
REQ-035 Program {100, 101, 111}, op_done tied 1 -> valid then store pulses, each 1 cycle, 3 cycles apart (EXEC, WAIT, FETCH).
REQ-036 PC_W=2, four NOPs, instr_valid always 1 -> pc sequence 0,1,2,3,0.
REQ-037 reset=0 during WAIT of LOAD_INPUTS -> all outputs 0 same cycle, IDLE; later op_done ignored.
REQ-038 With CTRL_SEQ_LOOP_EN: {011, LOOP count=3 target=0, 111}, op_done=1 -> load_input pulses 4 times then halted; without macro -> 1 pulse.

Source files
------------

// File: rtl/control_sequencer.sv
// Instruction-driven control sequencer: fetches opcodes, issues one-cycle datapath strobes and
// waits for completion. Define CTRL_SEQ_LOOP_EN to enable the single-level LOOP opcode.
module control_sequencer #(
   parameter int unsigned INSTR_W = 16,
   parameter int unsigned OPC_W   = 3,
   parameter int unsigned PC_W    = 8,
   localparam int unsigned ADDR_W = INSTR_W - OPC_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   output logic [PC_W-1:0]    pc,
   input  logic [INSTR_W-1:0] instr,
   input  logic               instr_valid,
   input  logic               op_done,
   output logic [ADDR_W-1:0]  base_address,
   output logic               load_weight,
   output logic               load_input,
   output logic               valid,
   output logic               store,
   output logic               busy,
   output logic               halted
);

   if (PC_W > ADDR_W - 1) begin : g_pc_w_check
      $error("control_sequencer: PC_W must not exceed ADDR_W-1");
   end

   localparam logic [OPC_W-1:0] OpNop   = OPC_W'(0);
   localparam logic [OPC_W-1:0] OpLdAdr = OPC_W'(1);
   localparam logic [OPC_W-1:0] OpLdW   = OPC_W'(2);
   localparam logic [OPC_W-1:0] OpLdIn  = OPC_W'(3);
   localparam logic [OPC_W-1:0] OpValid = OPC_W'(4);
   localparam logic [OPC_W-1:0] OpStore = OPC_W'(5);
   localparam logic [OPC_W-1:0] OpLoop  = OPC_W'(6);
   localparam logic [OPC_W-1:0] OpHalt  = OPC_W'(7);

   typedef enum logic [2:0] {StIdle, StFetch, StExec, StWait, StHalt} state_e;

   state_e state_q, state_d;

   logic [PC_W-1:0]    pc_q, pc_d;
   logic [ADDR_W-1:0]  base_q, base_d;
   logic [INSTR_W-1:0] ir_q, ir_d;
   logic               lw_q, lw_d, li_q, li_d, vl_q, vl_d, st_q, st_d;
   logic [OPC_W-1:0]   opc;
   logic [PC_W-1:0]    pc_inc;

   assign opc    = ir_q[INSTR_W-1 -: OPC_W];
   assign pc_inc = pc_q + PC_W'(1);

`ifdef CTRL_SEQ_LOOP_EN
   localparam int unsigned CNT_W = ADDR_W - PC_W;
   logic [CNT_W-1:0] loop_cnt_q, loop_cnt_d, loop_count;
   logic             loop_active_q, loop_active_d;
   logic [PC_W-1:0]  loop_target;

   assign loop_count  = ir_q[ADDR_W-1:PC_W];
   assign loop_target = ir_q[PC_W-1:0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         loop_cnt_q    <= '0;
         loop_active_q <= 1'b0;
      end else begin
         loop_cnt_q    <= loop_cnt_d;
         loop_active_q <= loop_active_d;
      end
   end
`endif

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= StIdle;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StFetch;
         StFetch: if (instr_valid) state_d = StExec;
         StExec: begin
            case (opc)
               OpLdW, OpLdIn, OpValid, OpStore: state_d = StWait;
               OpHalt:                          state_d = StHalt;
               default:                         state_d = StFetch;
            endcase
         end
         StWait:  if (op_done) state_d = StFetch;
         StHalt:  if (start) state_d = StFetch;
         default: state_d = StIdle;
      endcase
   end

   // Status outputs
   always_comb begin
      busy   = (state_q == StFetch) || (state_q == StExec) || (state_q == StWait);
      halted = (state_q == StHalt);
   end

   // Datapath next values
   always_comb begin
      pc_d   = pc_q;
      base_d = base_q;
      ir_d   = ir_q;
      lw_d   = 1'b0;
      li_d   = 1'b0;
      vl_d   = 1'b0;
      st_d   = 1'b0;
`ifdef CTRL_SEQ_LOOP_EN
      loop_cnt_d    = loop_cnt_q;
      loop_active_d = loop_active_q;
`endif
      unique case (state_q)
         StIdle:  pc_d = '0;
         StFetch: if (instr_valid) ir_d = instr;
         StExec: begin
            case (opc)
               OpNop:   pc_d = pc_inc;
               OpLdAdr: begin
                  base_d = ir_q[ADDR_W-1:0];
                  pc_d   = pc_inc;
               end
               OpLdW:   lw_d = 1'b1;
               OpLdIn:  li_d = 1'b1;
               OpValid: vl_d = 1'b1;
               OpStore: st_d = 1'b1;
               OpLoop: begin
`ifdef CTRL_SEQ_LOOP_EN
                  // Single level: a nested LOOP reuses the one counter.
                  if (!loop_active_q) begin
                     if (loop_count == '0) begin
                        pc_d = pc_inc;
                     end else begin
                        loop_cnt_d    = loop_count - CNT_W'(1);
                        loop_active_d = 1'b1;
                        pc_d          = loop_target;
                     end
                  end else if (loop_cnt_q == '0) begin
                     loop_active_d = 1'b0;
                     pc_d          = pc_inc;
                  end else begin
                     loop_cnt_d = loop_cnt_q - CNT_W'(1);
                     pc_d       = loop_target;
                  end
`else
                  pc_d = pc_inc;
`endif
               end
               OpHalt:  pc_d = pc_q;
               default: pc_d = pc_q;
            endcase
         end
         StWait: if (op_done) pc_d = pc_inc;
         StHalt: begin
            if (start) begin
               pc_d = '0;
`ifdef CTRL_SEQ_LOOP_EN
               loop_cnt_d    = '0;
               loop_active_d = 1'b0;
`endif
            end
         end
         default: pc_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q   <= '0;
         base_q <= '0;
         ir_q   <= '0;
         lw_q   <= 1'b0;
         li_q   <= 1'b0;
         vl_q   <= 1'b0;
         st_q   <= 1'b0;
      end else begin
         pc_q   <= pc_d;
         base_q <= base_d;
         ir_q   <= ir_d;
         lw_q   <= lw_d;
         li_q   <= li_d;
         vl_q   <= vl_d;
         st_q   <= st_d;
      end
   end

   assign pc           = pc_q;
   assign base_address = base_q;
   assign load_weight  = lw_q;
   assign load_input   = li_q;
   assign valid        = vl_q;
   assign store        = st_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer; a second instance with PC_W=2 covers wrap.
module tb_control_sequencer;

   logic        clk;
   logic        reset;
   logic        start;
   logic [7:0]  pc;
   logic [15:0] instr;
   logic        instr_valid;
   logic        op_done;
   logic [12:0] base_address;
   logic        load_weight, load_input, valid, store, busy, halted;

   logic        s_start;
   logic [1:0]  s_pc;
   logic [15:0] s_instr;
   logic        s_instr_valid;
   logic        s_op_done;
   logic [12:0] s_base;
   logic        s_lw, s_li, s_vl, s_st, s_busy, s_halted;

   logic [15:0] prog [256];

   int checks;
   int errors;
   int n_lw, n_li, n_vl, n_st, n_multi;

   control_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .pc(pc), .instr(instr),
      .instr_valid(instr_valid), .op_done(op_done), .base_address(base_address),
      .load_weight(load_weight), .load_input(load_input), .valid(valid), .store(store),
      .busy(busy), .halted(halted)
   );

   control_sequencer #(.PC_W(2)) dut_small (
      .clk(clk), .reset(reset), .start(s_start), .pc(s_pc), .instr(s_instr),
      .instr_valid(s_instr_valid), .op_done(s_op_done), .base_address(s_base),
      .load_weight(s_lw), .load_input(s_li), .valid(s_vl), .store(s_st),
      .busy(s_busy), .halted(s_halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb instr = prog[pc];

   always @(negedge clk) begin
      if (load_weight) n_lw++;
      if (load_input) n_li++;
      if (valid) n_vl++;
      if (store) n_st++;
      if ((32'(load_weight) + 32'(load_input) + 32'(valid) + 32'(store)) > 1) n_multi++;
   end

   function automatic logic [15:0] mk(input logic [2:0] o, input logic [12:0] a);
      return {o, a};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_prog();
      for (int i = 0; i < 256; i++) prog[i] = mk(3'd7, 13'd0);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #2;
      checks++;
      if ({pc, base_address} !== 21'd0) begin
         errors++;
         $display("FAIL reset_regs: pc=%0h base=%0h, required 0", pc, base_address);
      end
      checks++;
      if ({load_weight, load_input, valid, store, busy, halted} !== 6'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %b, required 000000",
                  {load_weight, load_input, valid, store, busy, halted});
      end
      tick();
      reset = 1'b1;
      tick(); tick(); tick();
      checks++;
      if (busy !== 1'b0 || pc !== 8'd0 || n_lw + n_li + n_vl + n_st != 0) begin
         errors++;
         $display("FAIL idle_no_start: busy=%b pc=%0d strobes=%0d, required 0/0/0",
                  busy, pc, n_lw + n_li + n_vl + n_st);
      end
   endtask

   task automatic test_load_addr_halt();
      int s0;
      clear_prog();
      prog[0] = mk(3'd1, 13'h0A5);
      prog[1] = mk(3'd7, 13'd0);
      s0 = n_lw + n_li + n_vl + n_st;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL start_busy: busy=%b, required 1", busy);
      end
      tick(); tick();
      checks++;
      if (base_address !== 13'h0A5 || pc !== 8'd1) begin
         errors++;
         $display("FAIL load_addr: base=%0h pc=%0d, required 0a5/1", base_address, pc);
      end
      tick(); tick();
      tick();
      checks++;
      if (halted !== 1'b1 || busy !== 1'b0 || pc !== 8'd1) begin
         errors++;
         $display("FAIL halt_state: halted=%b busy=%b pc=%0d, required 1/0/1", halted, busy, pc);
      end
      checks++;
      if (n_lw + n_li + n_vl + n_st != s0) begin
         errors++;
         $display("FAIL no_strobes: got %0d pulses, required 0", n_lw + n_li + n_vl + n_st - s0);
      end
   endtask

   task automatic test_wait();
      int s0;
      bit ok;
      clear_prog();
      prog[0] = mk(3'd2, 13'h123);
      op_done = 1'b0;
      s0 = n_lw;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (pc !== 8'd0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL restart: pc=%0d busy=%b, required 0/1", pc, busy);
      end
      tick(); tick();
      checks++;
      if (load_weight !== 1'b1) begin
         errors++;
         $display("FAIL lw_pulse: load_weight=%b, required 1", load_weight);
      end
      ok = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (busy !== 1'b1 || pc !== 8'd0) ok = 1'b0;
         tick();
         if (load_weight !== 1'b0) ok = 1'b0;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL wait_hold: busy=%b pc=%0d lw=%b, required 1/0/0", busy, pc, load_weight);
      end
      op_done = 1'b1;
      tick();
      op_done = 1'b0;
      checks++;
      if (pc !== 8'd1 || busy !== 1'b1 || n_lw - s0 != 1) begin
         errors++;
         $display("FAIL wait_done: pc=%0d busy=%b pulses=%0d, required 1/1/1",
                  pc, busy, n_lw - s0);
      end
      checks++;
      if (base_address !== 13'h0A5) begin
         errors++;
         $display("FAIL base_hold: base=%0h, required 0a5", base_address);
      end
      tick(); tick();
   endtask

   task automatic test_back_to_back();
      clear_prog();
      prog[0] = mk(3'd4, 13'd0);
      prog[1] = mk(3'd5, 13'd0);
      op_done = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      checks++;
      if (valid !== 1'b1 || store !== 1'b0) begin
         errors++;
         $display("FAIL valid_pulse: valid=%b store=%b, required 1/0", valid, store);
      end
      start = 1'b1;
      tick();
      checks++;
      if (valid !== 1'b0 || pc !== 8'd1) begin
         errors++;
         $display("FAIL valid_end: valid=%b pc=%0d, required 0/1", valid, pc);
      end
      tick();
      start = 1'b0;
      checks++;
      if (store !== 1'b0 || valid !== 1'b0) begin
         errors++;
         $display("FAIL gap: valid=%b store=%b, required 0/0", valid, store);
      end
      tick();
      checks++;
      if (store !== 1'b1 || valid !== 1'b0) begin
         errors++;
         $display("FAIL store_pulse: store=%b valid=%b, required 1/0", store, valid);
      end
      tick(); tick(); tick();
      checks++;
      if (halted !== 1'b1 || store !== 1'b0 || pc !== 8'd2) begin
         errors++;
         $display("FAIL b2b_halt: halted=%b store=%b pc=%0d, required 1/0/2", halted, store, pc);
      end
      op_done = 1'b0;
   endtask

   task automatic test_pc_wrap();
      logic [1:0] exp_pc [5];
      bit ok;
      exp_pc[0] = 2'd0; exp_pc[1] = 2'd1; exp_pc[2] = 2'd2; exp_pc[3] = 2'd3; exp_pc[4] = 2'd0;
      ok = 1'b1;
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (s_pc !== exp_pc[i] || s_busy !== 1'b1) begin
            ok = 1'b0;
            $display("FAIL pc_wrap_step%0d: pc=%0d, required %0d", i, s_pc, exp_pc[i]);
         end
         tick(); tick();
      end
      checks++;
      if (!ok) errors++;
   endtask

   task automatic test_reset_mid_wait();
      int s0;
      clear_prog();
      prog[0] = mk(3'd3, 13'd0);
      op_done = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      checks++;
      if (load_input !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL li_pulse: load_input=%b busy=%b, required 1/1", load_input, busy);
      end
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if ({load_weight, load_input, valid, store, busy, halted} !== 6'd0 ||
          pc !== 8'd0 || base_address !== 13'd0) begin
         errors++;
         $display("FAIL reset_mid_wait: outs=%b pc=%0d base=%0h, required 0",
                  {load_weight, load_input, valid, store, busy, halted}, pc, base_address);
      end
      s0 = n_lw + n_li + n_vl + n_st;
      op_done = 1'b1;
      tick();
      reset = 1'b1;
      tick(); tick(); tick();
      checks++;
      if (busy !== 1'b0 || pc !== 8'd0 || n_lw + n_li + n_vl + n_st != s0) begin
         errors++;
         $display("FAIL op_done_ignored: busy=%b pc=%0d pulses=%0d, required 0/0/0",
                  busy, pc, n_lw + n_li + n_vl + n_st - s0);
      end
      op_done = 1'b0;
   endtask

   task automatic test_loop();
      int s0;
      int exp_li;
      bit done;
`ifdef CTRL_SEQ_LOOP_EN
      exp_li = 4;
`else
      exp_li = 1;
`endif
      clear_prog();
      prog[0] = mk(3'd3, 13'd0);
      prog[1] = mk(3'd6, {5'd3, 8'd0});
      prog[2] = mk(3'd7, 13'd0);
      op_done = 1'b1;
      s0 = n_li;
      start = 1'b1;
      tick();
      start = 1'b0;
      done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         tick();
         if (halted === 1'b1) done = 1'b1;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL loop_timeout: halted=%b after 100 cycles, required 1", halted);
      end
      checks++;
      if (n_li - s0 != exp_li || pc !== 8'd2) begin
         errors++;
         $display("FAIL loop_pulses: got %0d pulses pc=%0d, required %0d pulses pc=2",
                  n_li - s0, pc, exp_li);
      end
      op_done = 1'b0;
   endtask

   task automatic test_one_hot();
      checks++;
      if (n_multi != 0) begin
         errors++;
         $display("FAIL one_hot: %0d cycles with multiple strobes, required 0", n_multi);
      end
   endtask

   initial begin
      checks = 0; errors = 0;
      n_lw = 0; n_li = 0; n_vl = 0; n_st = 0; n_multi = 0;
      reset = 1'b1; start = 1'b0; instr_valid = 1'b1; op_done = 1'b0;
      s_start = 1'b0; s_instr = 16'h0000; s_instr_valid = 1'b1; s_op_done = 1'b0;
      clear_prog();
      test_reset();
      test_load_addr_halt();
      test_wait();
      test_back_to_back();
      test_pc_wrap();
      test_reset_mid_wait();
      test_loop();
      test_one_hot();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
